// File: rtl/byte_serializer_if.sv
// byte_serializer_if: valid/ready word handshake feeding the serializer.
interface byte_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  modport master (output data_in, data_valid, input data_ready);
  modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: parallel word to bit-strobed serial stream with gapless back-to-back frames.
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  byte_serializer_if.slave  bus,
  output logic              sdata,
  output logic              sdata_valid,
  output logic              frame_last
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sdata_q, sdata_d;
  logic             sdata_valid_q, sdata_valid_d;
  logic             frame_last_q, frame_last_d;
  logic             last, accept;
  assign last           = state_q == SHIFT && cnt_q == '0;
  assign bus.data_ready = reset && (state_q == IDLE || (last && bit_en));
  assign accept         = bus.data_valid && bus.data_ready;
  // sdata is the bit the shift register will present next cycle, so it is taken from sh_d
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CW'(WIDTH - 1);
      sh_d    = bus.data_in;
    end else if (state_q == SHIFT && bit_en) begin
      if (last) state_d = IDLE;
      else begin
        cnt_d = cnt_q - CW'(1);
        sh_d  = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
      end
    end
    sdata_valid_d = state_d == SHIFT;
    frame_last_d  = state_d == SHIFT && cnt_d == '0;
    sdata_d       = state_d == SHIFT ? (MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0]) : IDLE_BIT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      sdata_q       <= IDLE_BIT;
      sdata_valid_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      sdata_q       <= sdata_d;
      sdata_valid_q <= sdata_valid_d;
      frame_last_q  <= frame_last_d;
    end
  end
  assign sdata       = sdata_q;
  assign sdata_valid = sdata_valid_q;
  assign frame_last  = frame_last_q;
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed vectors for MSB-first and LSB-first serializers.
module tb_byte_serializer;
  logic clk = 1'b0;
  logic reset, bit_en;
  logic sdata, sdata_valid, frame_last;
  logic sdata1, sdata_valid1, frame_last1;
  int checks = 0;
  int failures = 0;
  byte_serializer_if #(.WIDTH(8)) bus ();
  byte_serializer_if #(.WIDTH(8)) bus1 ();
  byte_serializer dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .bus(bus),
    .sdata(sdata), .sdata_valid(sdata_valid), .frame_last(frame_last)
  );
  byte_serializer #(.MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bit_en(bit_en), .bus(bus1),
    .sdata(sdata1), .sdata_valid(sdata_valid1), .frame_last(frame_last1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [7:0] w);
    bus.data_in = w;
    bus.data_valid = 1'b1;
    bit_en = 1'b1;
    #1;
    chk("acc_ready", bus.data_ready, 1);
    cyc();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("f_sdata", sdata, w[7-i]);
      chk("f_valid", sdata_valid, 1);
      chk("f_last", frame_last, i == 7);
      chk("f_ready", bus.data_ready, i == 7);
      cyc();
    end
    chk("f_idle_valid", sdata_valid, 0);
    chk("f_idle_sdata", sdata, 0);
    chk("f_idle_last", frame_last, 0);
  endtask
  initial begin
    logic [15:0] stream;
    logic [7:0] w;
    reset = 1'b0;
    bit_en = 1'b1;
    bus.data_in = 8'hFF;
    bus.data_valid = 1'b1;
    bus1.data_in = 8'h00;
    bus1.data_valid = 1'b0;
    cyc();
    cyc();
    chk("rst_sdata", sdata, 0);
    chk("rst_valid", sdata_valid, 0);
    chk("rst_last", frame_last, 0);
    chk("rst_ready", bus.data_ready, 0);
    cyc();
    chk("rst_hold_valid", sdata_valid, 0);
    reset = 1'b1;
    bus.data_valid = 1'b0;
    frame(8'h90);
    // back-to-back frames with data_valid held high
    stream = 16'h9009;
    bus.data_in = 8'h90;
    bus.data_valid = 1'b1;
    #1;
    chk("b2b_acc_ready", bus.data_ready, 1);
    cyc();
    bus.data_in = 8'h09;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) bus.data_valid = 1'b0;
      #1;
      chk("b2b_sdata", sdata, stream[15-i]);
      chk("b2b_valid", sdata_valid, 1);
      chk("b2b_last", frame_last, i == 7 || i == 15);
      chk("b2b_ready", bus.data_ready, i == 7 || i == 15);
      cyc();
    end
    chk("b2b_end_valid", sdata_valid, 0);
    // bit_en every third cycle
    w = 8'hA5;
    bit_en = 1'b0;
    bus.data_in = w;
    bus.data_valid = 1'b1;
    #1;
    chk("slow_acc_ready", bus.data_ready, 1);
    cyc();
    bus.data_valid = 1'b0;
    for (int j = 0; j < 24; j++) begin
      bit_en = (j % 3) == 2;
      #1;
      chk("slow_sdata", sdata, w[7 - j/3]);
      chk("slow_valid", sdata_valid, 1);
      chk("slow_last", frame_last, j >= 21);
      chk("slow_ready", bus.data_ready, j == 23);
      cyc();
    end
    chk("slow_end_valid", sdata_valid, 0);
    // reset during the 4th bit of 8'hFF
    bit_en = 1'b1;
    bus.data_in = 8'hFF;
    bus.data_valid = 1'b1;
    cyc();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rmid_sdata", sdata, 1);
      cyc();
    end
    chk("rmid_4th", sdata, 1);
    reset = 1'b0;
    bus.data_valid = 1'b1;
    #1;
    chk("rmid_ready_low", bus.data_ready, 0);
    cyc();
    chk("rmid_sdata0", sdata, 0);
    chk("rmid_valid0", sdata_valid, 0);
    chk("rmid_last0", frame_last, 0);
    chk("rmid_ready0", bus.data_ready, 0);
    bus.data_valid = 1'b0;
    cyc();
    chk("rmid_still_idle", sdata_valid, 0);
    reset = 1'b1;
    frame(8'h81);
    // word offered mid-frame waits for the last-bit bit_en cycle
    w = 8'h11;
    bus.data_in = w;
    bus.data_valid = 1'b1;
    cyc();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        bus.data_in = 8'h3C;
        bus.data_valid = 1'b1;
      end
      #1;
      chk("mid_sdata", sdata, w[7-i]);
      chk("mid_ready", bus.data_ready, i == 7);
      cyc();
    end
    bus.data_valid = 1'b0;
    w = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("mid2_sdata", sdata, w[7-i]);
      chk("mid2_valid", sdata_valid, 1);
      chk("mid2_last", frame_last, i == 7);
      cyc();
    end
    chk("mid2_end_valid", sdata_valid, 0);
    // LSB-first instance
    bus1.data_in = 8'h01;
    bus1.data_valid = 1'b1;
    #1;
    chk("lsb_acc_ready", bus1.data_ready, 1);
    cyc();
    bus1.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("lsb_sdata", sdata1, i == 0);
      chk("lsb_valid", sdata_valid1, 1);
      chk("lsb_last", frame_last1, i == 7);
      cyc();
    end
    chk("lsb_end_valid", sdata_valid1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the parallel word width in bits (minimum 2).
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 Parameter IDLE_BIT, default 0, is the sdata level driven whenever no frame is active.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  reset is synchronous and active-low, sampled on clk rising edge.
REQ-006 Port bit_en  input  1  bit-rate strobe; the current serial bit advances only in cycles where bit_en=1.
REQ-007 Port data_in  input  WIDTH  parallel word, sampled only on an accepted handshake.
REQ-008 Port data_valid  input  1  source has a word on data_in.
REQ-009 Port data_ready  output  1  block can accept a word this cycle.
REQ-010 Port sdata  output  1  serial bit stream; directly drives a downstream sequence detector's din.
REQ-011 Port sdata_valid  output  1  high while sdata carries a frame bit.
REQ-012 Port frame_last  output  1  high while sdata carries the final bit of a word.

Function
REQ-013 Handshake: word accepted in a cycle where data_valid=1 and data_ready=1; no other cycle samples data_in.
REQ-014 States IDLE and SHIFT; a registered shift register of WIDTH bits and a bit counter of ceil(log2(WIDTH)) bits.
REQ-015 IDLE: data_ready=1, sdata=IDLE_BIT, sdata_valid=0, frame_last=0; on accept, load word, counter=WIDTH-1, go SHIFT.
REQ-016 Latency: word accepted in cycle N puts its first bit on sdata, with sdata_valid=1, in cycle N+1, independent of bit_en.
REQ-017 SHIFT, bit_en=0: sdata, sdata_valid, frame_last, counter and shift register hold.
REQ-018 SHIFT, bit_en=1, counter>0: shift one position in the configured direction, counter decrements, next bit on sdata next cycle.
REQ-019 frame_last=1 exactly when state=SHIFT and counter=0.
REQ-020 data_ready is combinational: 1 in IDLE, or in SHIFT when counter=0 and bit_en=1; otherwise 0.
REQ-021 SHIFT, counter=0, bit_en=1, data_valid=1: load new word, counter=WIDTH-1, stay SHIFT; no idle gap between frames.
REQ-022 SHIFT, counter=0, bit_en=1, data_valid=0: go IDLE; next cycle sdata=IDLE_BIT, sdata_valid=0.
REQ-023 data_valid asserted while data_ready=0 is not accepted; the block neither stores nor drops it (source holds).
REQ-024 All outputs except data_ready are registered; no combinational path from data_in to sdata.

Reset
REQ-025 reset=0 at a rising edge forces IDLE, counter=0, shift register=0, sdata=IDLE_BIT, sdata_valid=0, frame_last=0, overriding all other inputs.
REQ-026 reset asserted mid-frame abandons remaining bits; no partial frame resumes after release.
REQ-027 data_ready=0 while reset=0; first accept possible in the first cycle with reset=1.

Verification
REQ-028 Defaults, bit_en=1, accept 8'h90 in cycle N -> sdata 1,0,0,1,0,0,0,0 in cycles N+1..N+8, frame_last only in N+8, sdata_valid=0 in N+9.
REQ-029 Back-to-back 8'h90 then 8'h09, data_valid held high -> 16 consecutive sdata_valid cycles, second accept in cycle N+8, stream 10010000 00001001.
REQ-030 bit_en=1 every third cycle, word 8'hA5 -> each bit held exactly 3 cycles, data_ready pulses once in the bit_en cycle of the last bit.
REQ-031 MSB_FIRST=0, word 8'h01 -> sdata 1,0,0,0,0,0,0,0; frame_last on the final 0.
REQ-032 reset=0 during 4th bit of 8'hFF -> next cycle sdata=0, sdata_valid=0, data_ready=0; after release new word 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
REQ-033 data_valid=1 with 8'h3C offered mid-frame (counter>0) -> data_ready=0, word not consumed until the last-bit bit_en cycle, then serialized intact.
